mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (I, read-only) and data
//  access (D, read/write). Sequences each transaction through IDLE/ACTIVE/READ/WRITE,
//  drives mem_read/mem_write toward memory and returns data/ack to the owner.
//  Round-robin on contention; a wait-state timeout aborts hung accesses.
// PARAMETERS
//  ADDR_WIDTH  32  address width, all ports
//  DATA_WIDTH  32  data width, all ports
//  TIMEOUT     15  max READ/WRITE cycles with mem_ready low before abort (>=1)
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high
//  i_req        in   1           fetch read request; held until i_ack
//  i_addr       in   ADDR_WIDTH  fetch address
//  i_rdata      out  DATA_WIDTH  fetch read data, valid with i_ack
//  i_ack        out  1           one-cycle completion pulse, I port
//  d_req        in   1           data request; held until d_ack
//  d_we         in   1           1 = write, 0 = read
//  d_addr       in   ADDR_WIDTH  data address
//  d_wdata      in   DATA_WIDTH  write data
//  d_rdata      out  DATA_WIDTH  data read data, valid with d_ack
//  d_ack        out  1           one-cycle completion pulse, D port
//  mem_read     out  1           memory read strobe
//  mem_write    out  1           memory write strobe
//  mem_addr     out  ADDR_WIDTH  memory address
//  mem_wdata    out  DATA_WIDTH  memory write data
//  mem_rdata    in   DATA_WIDTH  memory read data, sampled with mem_ready
//  mem_ready    in   1           memory completes current READ/WRITE
//  timeout_err  out  1           one-cycle pulse on aborted transaction
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; addr/data latches 0; counter 0; last_grant = D.
//  Reset mid-transaction: immediate return to IDLE; strobes drop; no ack issued.
//  States (2-bit): IDLE=00, ACTIVE=01, READ=10, WRITE=11.
//  IDLE: mask a port whose ack is high this cycle; if any unmasked req -> pick winner,
//   latch owner, addr, wdata, we (I forces we=0) -> ACTIVE. Else stay.
//  Arbitration: single requester wins; both -> port NOT equal to last_grant.
//  ACTIVE: one setup cycle, mem_addr/mem_wdata stable, no strobe -> READ if we=0 else WRITE.
//  READ/WRITE: mem_read (resp. mem_write) = 1 for whole state; never both high.
//   mem_ready=1 -> capture mem_rdata (READ only) into owner rdata reg, owner ack=1 next
//   cycle, last_grant=owner, counter cleared -> IDLE.
//   mem_ready=0 -> counter++; at counter == TIMEOUT-1 -> timeout_err=1 and owner ack=1
//   next cycle, owner rdata=0, last_grant=owner -> IDLE.
//  mem_ready outside READ/WRITE ignored. Acks/timeout_err registered, one cycle wide.
//  Latency: req high before edge 0, mem_ready high in first READ cycle -> ack high in
//   cycle after edge 2 (3 cycles). Back-to-back: new grant no earlier than ack cycle.
//  Requester dropping req mid-transaction: transaction completes, ack still issued.
//  i_rdata/d_rdata hold value until next ack on same port. mem_addr/mem_wdata hold
//   last latched value in IDLE. Counter width $clog2(TIMEOUT+1); no wrap possible.
// STRUCTURE
//  Package mem_arb_pkg: state typedef + encodings above, PORT_I=0 / PORT_D=1 constants.
//  Sub-module mem_arb_rr: combinational 2-way round-robin pick (reqs, mask,
//   last_grant -> grant, valid). FSM, latches, counter stay in mem_port_arbiter.
// TESTING
//  1 i_req, i_addr=0x10, mem_ready=1 first READ cycle, mem_rdata=0xDEADBEEF -> mem_read
//    1 cycle, mem_addr=0x10, i_ack 1 cycle 3 cycles after req, i_rdata=0xDEADBEEF.
//  2 i_req and d_req (we=1, addr 0x20, wdata 0x12345678) together after reset -> I
//    served first, then mem_write with mem_addr=0x20, mem_wdata=0x12345678, d_ack.
//  3 both reqs held for 4 transactions -> grant order I,D,I,D; one ack per transaction.
//  4 d read, mem_ready held 0 -> after 15 READ cycles timeout_err and d_ack pulse,
//    d_rdata=0, state IDLE; next I read completes normally.
//  5 reset asserted during WRITE -> mem_write 0 immediately, no d_ack, all outputs 0;
//    subsequent request serviced with normal 3-cycle latency.
//  6 mem_ready=1 while IDLE/ACTIVE -> no ack, no capture; strobes only in READ/WRITE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_READ   = 2'b10,
    ST_WRITE  = 2'b11
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to the
// port that did not win last time.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  logic [1:0] elig;

  always_comb begin
    elig  = reqs & ~mask;
    valid = |elig;
    grant = PORT_I;
    if (elig == 2'b11) begin
      grant = ~last_grant;
    end else if (elig[PORT_D]) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D),
// sequencing each transaction IDLE -> ACTIVE -> READ/WRITE with a wait-state timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  timeout_err,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester raises req with stable address/data and holds it
  // until its one-cycle ack; the memory finishes a READ/WRITE by raising mem_ready.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t            state, state_nx;
  logic                  owner;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt;
  logic                  last_grant;
  logic                  rr_grant, rr_valid;
  logic                  grant_en, done_ok, done_to;

  // A port whose ack is showing this cycle still has req high; masking it
  // keeps the completed request from being granted twice.
  mem_arb_rr u_rr (
    .reqs      ({d_req, i_req}),
    .mask      ({d_ack, i_ack}),
    .last_grant(last_grant),
    .grant     (rr_grant),
    .valid     (rr_valid)
  );

  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rr_valid) begin
          grant_en = 1'b1;
          state_nx = ST_ACTIVE;
        end
      end
      ST_ACTIVE: state_nx = we_q ? ST_WRITE : ST_READ;
      ST_READ, ST_WRITE: begin
        if (mem_ready) begin
          done_ok  = 1'b1;
          state_nx = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          done_to  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Transaction latches; an I grant carries no write data, so zero is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= PORT_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_en) begin
      owner <= rr_grant;
      if (rr_grant == PORT_D) begin
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= i_addr;
        wdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      last_grant  <= PORT_D;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
      if (done_ok || done_to) begin
        cnt         <= '0;
        last_grant  <= owner;
        timeout_err <= done_to;
        if (owner == PORT_D) begin
          d_ack <= 1'b1;
          if (done_to) begin
            d_rdata <= '0;
          end else if (state == ST_READ) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          i_ack <= 1'b1;
          if (done_to) begin
            i_rdata <= '0;
          end else if (state == ST_READ) begin
            i_rdata <= mem_rdata;
          end
        end
      end else if (state == ST_READ || state == ST_WRITE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign mem_read  = (state == ST_READ);
  assign mem_write = (state == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ack, d_ack, mem_read, mem_write, timeout_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time: a setup cycle (phase 0), then access cycles
  // numbered from 1; the access ends on mem_ready or after TO stalled cycles.
  logic          m_busy = 1'b0, m_owner = PORT_I, m_we = 1'b0, m_last = PORT_D;
  int            m_phase = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata_i = '0, m_rdata_d = '0;
  logic          m_ack_i = 1'b0, m_ack_d = 1'b0, m_to = 1'b0;
  logic          n_ai, n_ad, n_to, c_i, c_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_phase = 0; m_owner = PORT_I; m_we = 1'b0; m_last = PORT_D;
      m_addr = '0; m_wdata = '0; m_rdata_i = '0; m_rdata_d = '0;
      m_ack_i = 1'b0; m_ack_d = 1'b0; m_to = 1'b0;
    end else begin
      n_ai = 1'b0; n_ad = 1'b0; n_to = 1'b0;
      if (m_busy) begin
        if (m_phase == 0) begin
          m_phase = 1;
        end else if (mem_ready || m_phase == TO) begin
          if (!mem_ready) begin
            n_to = 1'b1;
            if (m_owner) m_rdata_d = '0; else m_rdata_i = '0;
          end else if (!m_we) begin
            if (m_owner) m_rdata_d = mem_rdata; else m_rdata_i = mem_rdata;
          end
          if (m_owner) n_ad = 1'b1; else n_ai = 1'b1;
          m_last = m_owner;
          m_busy = 1'b0;
        end else begin
          m_phase++;
        end
      end else begin
        c_i = i_req && !m_ack_i;
        c_d = d_req && !m_ack_d;
        if (c_i || c_d) begin
          m_owner = (c_i && c_d) ? !m_last : c_d;
          m_busy  = 1'b1;
          m_phase = 0;
          m_we    = m_owner && d_we;
          m_addr  = m_owner ? d_addr : i_addr;
          m_wdata = m_owner ? d_wdata : '0;
        end
      end
      m_ack_i = n_ai; m_ack_d = n_ad; m_to = n_to;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  logic [1:0] exp_state;
  always @(negedge clk) begin
    if (!m_busy) exp_state = 2'b00;
    else if (m_phase == 0) exp_state = 2'b01;
    else exp_state = m_we ? 2'b11 : 2'b10;
    check("state", dbg_state, exp_state);
    check("mem_read", mem_read, m_busy && m_phase >= 1 && !m_we);
    check("mem_write", mem_write, m_busy && m_phase >= 1 && m_we);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("i_ack", i_ack, m_ack_i);
    check("d_ack", d_ack, m_ack_d);
    check("timeout_err", timeout_err, m_to);
    check("i_rdata", i_rdata, m_rdata_i);
    check("d_rdata", d_rdata, m_rdata_d);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int   acks[$];
  int   rd_cycles;
  logic seen, ai, ad, i_pend, d_pend;

  initial begin
    do_reset();
    check("rst_state", dbg_state, 2'b00);
    check("rst_strobes", {mem_read, mem_write, i_ack, d_ack, timeout_err}, 5'b0);
    check("rst_mem_addr", mem_addr, 32'h0);

    // 1: single fetch, memory ready at once
    i_req = 1'b1; i_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("t1_active_nostrobe", {mem_read, i_ack}, 2'b00);
    tick();
    check("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h10);
    tick();
    check("t1_i_ack", i_ack, 1'b1);
    check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_read_done", mem_read, 1'b0);
    tick();
    check("t1_ack_one_cycle", i_ack, 1'b0);
    check("t1_no_regrant", dbg_state, 2'b00);
    i_req = 1'b0;
    tick();

    // 2: simultaneous requests after reset, I first then D write
    do_reset();
    i_req = 1'b1; i_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    mem_ready = 1'b1; mem_rdata = 32'h0000_1111;
    tick(); tick(); tick();
    check("t2_i_first", {i_ack, d_ack}, 2'b10);
    i_req = 1'b0;
    tick();
    check("t2_d_active", dbg_state, 2'b01);
    check("t2_mem_addr", mem_addr, 32'h20);
    check("t2_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    check("t2_mem_write", {mem_write, mem_read}, 2'b10);
    tick();
    check("t2_d_ack", {i_ack, d_ack}, 2'b01);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // 3: both held for four transactions
    do_reset();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    mem_ready = 1'b1;
    acks.delete();
    for (int c = 0; c < 40 && acks.size() < 4; c++) begin
      tick();
      if (i_ack) acks.push_back(0);
      if (d_ack) acks.push_back(1);
    end
    i_req = 1'b0; d_req = 1'b0;
    check("t3_ack_count", acks.size(), 4);
    for (int k = 0; k < acks.size() && k < 4; k++) check("t3_order", acks[k], k % 2);
    tick(); tick();

    // 4: D read timeout, after priming d_rdata with a real value
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick(); tick(); tick();
    check("t4_prime_ack", d_ack, 1'b1);
    check("t4_prime_rdata", d_rdata, 32'hA5A5A5A5);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_addr = 32'h40; mem_ready = 1'b0;
    rd_cycles = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (mem_read) rd_cycles++;
      if (d_ack) begin
        seen = 1'b1;
        check("t4_timeout_err", timeout_err, 1'b1);
        check("t4_d_rdata_zero", d_rdata, 32'h0);
        check("t4_idle", dbg_state, 2'b00);
      end
    end
    d_req = 1'b0;
    check("t4_ack_seen", seen, 1'b1);
    check("t4_read_cycles", rd_cycles, TO);
    i_req = 1'b1; i_addr = 32'h50; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick(); tick(); tick();
    check("t4_next_i_ack", {i_ack, timeout_err}, 2'b10);
    check("t4_next_i_rdata", i_rdata, 32'hCAFEF00D);
    i_req = 1'b0;
    tick();

    // 5: reset during WRITE
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h5555AAAA; mem_ready = 1'b0;
    tick(); tick();
    check("t5_in_write", mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t5_write_dropped", mem_write, 1'b0);
    check("t5_outputs_zero", {i_ack, d_ack, timeout_err, mem_read, dbg_state}, 6'b0);
    check("t5_addr_zero", mem_addr, 32'h0);
    check("t5_wdata_zero", mem_wdata, 32'h0);
    check("t5_i_rdata_zero", i_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_no_d_ack", d_ack, 1'b0);
    i_req = 1'b1; i_addr = 32'h70; mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    check("t5_lat_c0", i_ack, 1'b0);
    tick();
    check("t5_lat_c1", {mem_read, i_ack}, 2'b10);
    check("t5_lat_addr", mem_addr, 32'h70);
    tick();
    check("t5_lat_ack", i_ack, 1'b1);
    check("t5_lat_rdata", i_rdata, 32'h0BADF00D);
    i_req = 1'b0;

    // 6: mem_ready while idle is ignored
    mem_rdata = 32'hFFFF0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_no_ack", {i_ack, d_ack, mem_read, mem_write}, 4'b0);
      check("t6_rdata_kept", i_rdata, 32'h0BADF00D);
    end

    // Random traffic: requesters hold req until ack, may drop it once owned
    i_pend = 1'b0; d_pend = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      ai = i_ack; ad = d_ack;
      tick();
      if (i_pend) begin
        if (ai) begin
          i_pend = 1'b0; i_req = 1'b0;
        end else if (i_req && m_busy && m_owner == PORT_I && $urandom_range(0, 7) == 0) begin
          i_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_req = 1'b1; i_addr = $urandom;
      end
      if (d_pend) begin
        if (ad) begin
          d_pend = 1'b0; d_req = 1'b0;
        end else if (d_req && m_busy && m_owner == PORT_D && $urandom_range(0, 7) == 0) begin
          d_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1));
      end
      mem_rdata = $urandom;
      if (cyc % 400 < 40) mem_ready = 1'b0;
      else mem_ready = ($urandom_range(0, 2) != 0);
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 25; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
